// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: state width and the
// elaboration-time KMP transition/failure functions.
package seq_det_pkg;

    localparam int unsigned SEQ_MAX_LEN = 16;

    function automatic int unsigned seq_state_w(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // Longest k such that (first s pattern bits, then b) ends with the first k pattern bits.
    function automatic int unsigned seq_next(
        input logic [SEQ_MAX_LEN-1:0] pattern,
        input int unsigned            len,
        input int unsigned            s,
        input logic                   b
    );
        int unsigned best;
        int unsigned idx;
        logic        ok;
        logic        c;
        best = 0;
        for (int unsigned k = 1; k <= s + 1 && k <= len; k++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                idx = s + 1 - k + j;
                c   = (idx < s) ? pattern[len-1-idx] : b;
                if (c != pattern[len-1-j]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Longest proper prefix of the full pattern that is also a suffix of it.
    function automatic int unsigned seq_fail(
        input logic [SEQ_MAX_LEN-1:0] pattern,
        input int unsigned            len
    );
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned k = 1; k < len; k++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                if (pattern[len-1-j] != pattern[k-1-j]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag and synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q;

    always_comb begin
        count_d = count_q;
        if (en_i && inc_i && (count_q != '1)) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (clear_i) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_q | (count_d == '1);
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: KMP transition table fixed at elaboration,
// registered match output and a saturating match counter.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            clear,
    input  logic                            A,
    output logic                            match,
    output logic [seq_state_w(PAT_LEN)-1:0] S,
    output logic [CNT_W-1:0]                match_count,
    output logic                            cnt_sat
);

    localparam int unsigned SW      = seq_state_w(PAT_LEN);
    localparam int unsigned LAST    = PAT_LEN;
    localparam logic [SEQ_MAX_LEN-1:0] PAT_EXT = SEQ_MAX_LEN'(PATTERN);
    localparam int unsigned FAIL_S  = OVERLAP ? seq_fail(PAT_EXT, PAT_LEN) : 0;

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("moore_seq_detector: PAT_LEN must be in 2..16");
    end

    logic [SW-1:0] trans_tbl [0:PAT_LEN][0:1];
    logic [SW-1:0] S_q, S_d;
    logic          match_q;
    logic          hit;

    // The detected state reuses the row of its fallback state, so no runtime search is needed.
    for (genvar gs = 0; gs <= PAT_LEN; gs++) begin : g_state
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int unsigned SRC = (gs == PAT_LEN) ? FAIL_S : gs;
            assign trans_tbl[gs][gb] = SW'(seq_next(PAT_EXT, PAT_LEN, SRC, 1'(gb)));
        end
    end

    always_comb begin
        S_d = '0;
        for (int unsigned i = 0; i <= LAST; i++) begin
            if (S_q == SW'(i)) S_d = trans_tbl[i][A];
        end
    end

    assign hit = (S_d == SW'(PAT_LEN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            S_q     <= '0;
            match_q <= 1'b0;
        end else if (clear) begin
            S_q     <= '0;
            match_q <= 1'b0;
        end else if (en) begin
            S_q     <= S_d;
            match_q <= hit;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (en),
        .inc_i   (hit),
        .clear_i (clear),
        .count_o (match_count),
        .sat_o   (cnt_sat)
    );

    assign S     = S_q;
    assign match = match_q;

endmodule
